// File: rtl/sr_mon_pkg.sv
// rtl/sr_mon_pkg.sv - shared state encoding and SR request codes for the SR flip-flop monitor
package sr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } mon_state_e;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_ILL  = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_q <= q_q + W'(1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sr_ff_monitor.sv
// rtl/sr_ff_monitor.sv - checks an SR flip-flop's Q/Qbar against a reference model of its state
module sr_ff_monitor
  import sr_mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qbar,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             illegal,
  output logic             illegal_seen,
  output logic             halted,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count
);

  mon_state_e state_q;
  logic       exp_q_q;
  logic       exp_valid_q;
  logic       mismatch_q;
  logic       illegal_q;
  logic       illegal_seen_q;
  logic       halted_q;

  logic [1:0] sr;
  logic       model_upd;
  logic       compare;
  logic       mismatch_d;
  logic       illegal_d;

  assign sr        = {S, R};
  assign model_upd = en && ((state_q == SYNC) || (state_q == CHECK));
  assign compare   = en && (state_q == CHECK);
  // Q==Qbar is a broken response even when the model does not know the state.
  assign mismatch_d = compare && ((exp_valid_q && (Q != exp_q_q)) || (Q == Qbar));
  assign illegal_d  = model_upd && (sr == SR_ILL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      exp_q_q        <= 1'b0;
      exp_valid_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
      if (illegal_d) begin
        illegal_seen_q <= 1'b1;
      end

      if (model_upd) begin
        case (sr)
          SR_HOLD: ;
          SR_RST: begin
            exp_q_q     <= 1'b0;
            exp_valid_q <= 1'b1;
          end
          SR_SET: begin
            exp_q_q     <= 1'b1;
            exp_valid_q <= 1'b1;
          end
          SR_ILL: exp_valid_q <= 1'b0;
        endcase
      end

      case (state_q)
        IDLE:  if (en) state_q <= SYNC;
        SYNC:  if (en) state_q <= CHECK;
        CHECK: begin
          if (!en) begin
            state_q     <= IDLE;
            exp_valid_q <= 1'b0;
          end else if (STOP_ON_ERR && mismatch_d) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch_d),
    .q     (err_count)
  );

  sat_counter #(.W(CNT_W)) u_chk_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (compare && exp_valid_q),
    .q     (chk_count)
  );

  assign exp_q        = exp_q_q;
  assign exp_valid    = exp_valid_q;
  assign mismatch     = mismatch_q;
  assign illegal      = illegal_q;
  assign illegal_seen = illegal_seen_q;
  assign halted       = halted_q;

endmodule

// File: doc/sr_ff_monitor.md
# sr_ff_monitor

Synthesizable protocol monitor for the SR flip-flop interface. It watches the S/R stimulus and the Q/Qbar response and keeps its own reference model of the expected state. It flags mismatches, complement violations and illegal S=R=1 requests, and keeps saturating error and check counters. It sits beside any SR flip-flop instance, in benches or on-chip, as the checking end of the stimulus-driving path.

## Interface
- CNT_W, 8: width of err_count and chk_count.
- STOP_ON_ERR, 0: when 1, the first error latches the monitor into HALT.
- clk  in  1  rising-edge clock shared with the monitored flip-flop.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  monitor enable; sampled each edge.
- S, R  in  1 each  stimulus into the monitored flip-flop.
- Q, Qbar  in  1 each  response from the monitored flip-flop.
- exp_q  out  1  model's expected Q.
- exp_valid  out  1  exp_q is known.
- mismatch  out  1  one-cycle pulse: Q differs from expected, or Q==Qbar.
- illegal  out  1  one-cycle pulse: S=R=1 was sampled.
- illegal_seen  out  1  sticky version of illegal.
- halted  out  1  high while in HALT.
- err_count  out  CNT_W  saturating count of mismatch cycles.
- chk_count  out  CNT_W  saturating count of compared cycles.

Clock is `clk`. Reset is `reset`, a single clock domain, asynchronous, active-high.

## Operation
- FSM states: IDLE, SYNC, CHECK, HALT.
- IDLE → SYNC on an edge with en=1.
- SYNC → CHECK after one enabled edge. This edge loads the model only; no compare is made.
- CHECK → IDLE when en=0. Model state is retained; exp_valid is cleared.
- CHECK → HALT on the first mismatch when STOP_ON_ERR=1.
- HALT is left only by reset.
- Model update on each enabled edge in SYNC or CHECK, from the sampled {S,R}:
  - 00: hold.
  - 01: exp_q=0, exp_valid=1.
  - 10: exp_q=1, exp_valid=1.
  - 11: exp_valid=0 and exp_q unchanged; illegal pulses and illegal_seen sets.
- Compare in CHECK, at edge k+1, against the model value registered at edge k:
  - Q≠exp_q while exp_valid=1 → mismatch.
  - Q==Qbar → mismatch, regardless of exp_valid.
- chk_count increments on every CHECK edge where exp_valid=1.
- err_count increments once per mismatch cycle, even when both error causes hold.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- In HALT: counters and model freeze, and no pulses are produced.
- Simultaneous illegal and mismatch in one cycle: both pulse, and err_count increments by 1.

## Timing
- Reset values: state=IDLE, exp_q=0, exp_valid=0, mismatch=0, illegal=0, illegal_seen=0, halted=0, err_count=0, chk_count=0.
- Reset is asynchronous. Asserting it mid-CHECK or in HALT clears everything immediately.
- mismatch and illegal are registered. Each is high for exactly the one cycle after the offending edge.
- Latency: a bad Q driven in response to the {S,R} sampled at edge k is reported at edge k+1, and mismatch is visible after that edge.
- halted rises in the same cycle as the mismatch pulse that caused it.
- en is sampled per edge. Deasserting en does not clear the counters.

## Structure
- Package sr_mon_pkg holds:
  - the state enum (IDLE, SYNC, CHECK, HALT);
  - SR code localparams SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILL=2'b11.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, q), instantiated twice: once for err_count and once for chk_count.
- FSM, reference model and compare logic live in the top module.

## Test plan
- Reset held, then released with en=1, {S,R}=01 → next edge SYNC, then CHECK; exp_q=0, exp_valid=1; with Q=0/Qbar=1, chk_count increments each edge and err_count stays 0.
- Sequence {S,R}=01, 00, 10, 00 with a correct DUT → exp_q follows 0, 0, 1, 1; no mismatch; chk_count=3 after the sequence.
- {S,R}=11 sampled → illegal pulses for 1 cycle, illegal_seen=1, exp_valid=0; a following 10 restores exp_valid=1, exp_q=1.
- DUT forced to Q=0 after a SET (STOP_ON_ERR=0) → mismatch for 1 cycle, err_count=1; Q=Qbar=1 on the next edge gives err_count=2.
- STOP_ON_ERR=1 with one injected error → halted=1 and counters frozen; further errors produce no pulses; asserting reset returns all outputs to reset values asynchronously.
- CNT_W=2 with 5 injected errors → err_count saturates at 3.
